// File: rtl/add4_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : add4_seq_ctrl
//  Purpose  : Wide adder sequencer. It computes A + B + Cin over 4*NIBBLES bits
//             by time-multiplexing one external 4-bit adder slice, one nibble
//             per cycle, least-significant nibble first. The slice carry-out
//             of each nibble is the carry-in of the next nibble.
//  Ports    : clk, rst           clock, synchronous active-high reset
//             start_valid/ready  operand handshake (A_in, B_in, Cin_in)
//             add_a/b/cin        drive the external add4 slice
//             add_sum/cout       combinational result of the add4 slice
//             Sum, Cout          registered result
//             done_valid/ready   result handshake
//             busy               high while an operation is in progress
//  Revision : 1.0  initial release
// ============================================================================
module add4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   A_in,
  input  logic [4*NIBBLES-1:0]   B_in,
  input  logic                   Cin_in,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   Cout,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic                   busy
);

  localparam int c_w     = 4 * NIBBLES;
  // Nibble index needs at least one bit even for a single-nibble adder.
  localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [c_idx_w-1:0] r_idx;
  logic [c_w-1:0]     r_a;
  logic [c_w-1:0]     r_b;
  logic               r_carry;
  logic [c_w-1:0]     r_sum;
  logic               r_cout;

  // Bit offset of the current nibble (idx * 4).
  logic [c_idx_w+1:0] w_base;
  logic               w_last;

  assign w_base = {r_idx, 2'b00};
  assign w_last = (r_idx == c_last_idx);

  // --------------------------------------------------------------------------
  // Sequencer. Operands and carry-in are captured on acceptance so that the
  // input ports may change freely while the operation runs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start_valid) begin
            r_a     <= A_in;
            r_b     <= B_in;
            r_carry <= Cin_in;
            r_sum   <= '0;
            r_idx   <= '0;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          r_sum[w_base +: 4] <= add_sum;
          r_carry            <= add_cout;
          if (w_last) begin
            // Carry out of the top nibble is the operation's carry-out.
            r_cout  <= add_cout;
            r_idx   <= '0;
            r_state <= c_st_done;
          end else begin
            r_idx <= r_idx + c_idx_w'(1);
          end
        end
        c_st_done: begin
          // Returning through IDLE means a new operand is accepted no earlier
          // than one cycle after the result handshake.
          if (done_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Slice drive: only the current nibble while running, zeros otherwise.
  // --------------------------------------------------------------------------
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (r_state == c_st_run) begin
      add_a   = r_a[w_base +: 4];
      add_b   = r_b[w_base +: 4];
      add_cin = r_carry;
    end
  end

  // start_ready is masked by rst so nothing looks acceptable during reset.
  assign start_ready = (r_state == c_st_idle) && !rst;
  assign done_valid  = (r_state == c_st_done);
  assign busy        = (r_state != c_st_idle);
  assign Sum         = r_sum;
  assign Cout        = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_add4_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add4_seq_ctrl
//  Purpose  : Self-checking bench for add4_seq_ctrl. A 4-nibble instance is
//             compared every cycle against an arithmetic reference model and
//             exercised with directed vectors; a 2-nibble instance is swept
//             over a grid of operand values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add4_seq_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4-nibble DUT ----------------
  logic        rst, start_valid, start_ready, Cin_in, add_cin, add_cout;
  logic [15:0] A_in, B_in, Sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        Cout, done_valid, done_ready, busy;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  add4_seq_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .A_in(A_in), .B_in(B_in), .Cin_in(Cin_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .Sum(Sum), .Cout(Cout), .done_valid(done_valid), .done_ready(done_ready),
    .busy(busy)
  );

  // ---------------- 2-nibble DUT ----------------
  logic       sv2, sr2, c2, ac2, aco2, co2, dv2, dr2, busy2;
  logic [7:0] a2, b2, s2;
  logic [3:0] aa2, ab2, as2;

  assign {aco2, as2} = {1'b0, aa2} + {1'b0, ab2} + {4'b0, ac2};

  add4_seq_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
    .A_in(a2), .B_in(b2), .Cin_in(c2),
    .add_a(aa2), .add_b(ab2), .add_cin(ac2),
    .add_sum(as2), .add_cout(aco2),
    .Sum(s2), .Cout(co2), .done_valid(dv2), .done_ready(dr2),
    .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (4-nibble DUT) ----------------
  // m_phase: 0 = idle, 1..N = running with (m_phase-1) nibbles done, N+1 = done.
  int          m_phase = 0;
  bit          m_ok = 1'b0;
  logic [15:0] m_a = '0, m_b = '0, m_sum = '0;
  logic        m_cin = 1'b0, m_cout = 1'b0;

  // Sum of the low k nibbles of A and B plus carry-in, as a 17-bit value.
  function automatic logic [16:0] part(input int k);
    logic [16:0] mk;
    mk = (17'd1 << (4 * k)) - 17'd1;
    return ({1'b0, m_a} & mk) + ({1'b0, m_b} & mk) + {16'b0, m_cin};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      if (m_phase == 0) begin
        if (start_valid) begin
          m_a = A_in; m_b = B_in; m_cin = Cin_in; m_sum = '0; m_phase = 1;
        end
      end else if (m_phase <= N) begin
        m_phase++;
        if (m_phase == N + 1)
          {m_cout, m_sum} = {1'b0, m_a} + {1'b0, m_b} + {16'b0, m_cin};
      end else if (done_ready) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      logic [16:0] p;
      logic [16:0] mk;
      int k;
      chk("start_ready", 32'(start_ready), 32'(m_phase == 0 && !rst));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done_valid", 32'(done_valid), 32'(m_phase == N + 1));
      chk("Cout", 32'(Cout), 32'(m_cout));
      if (m_phase >= 1 && m_phase <= N) begin
        k  = m_phase - 1;
        p  = part(k);
        mk = (17'd1 << (4 * k)) - 17'd1;
        chk("run_Sum", 32'(Sum), 32'(p & mk));
        chk("add_a", 32'(add_a), 32'((m_a >> (4 * k)) & 16'hF));
        chk("add_b", 32'(add_b), 32'((m_b >> (4 * k)) & 16'hF));
        chk("add_cin", 32'(add_cin), 32'((p >> (4 * k)) & 17'd1));
      end else begin
        chk("Sum", 32'(Sum), 32'(m_sum));
        if (m_phase == 0)
          chk("idle_add", 32'({add_a, add_b, add_cin}), 32'd0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] seq_a[N];
  logic       seq_cin[N];
  int         acc_cyc;

  // Call at posedge+1 with the DUT idle; returns at the first negedge with
  // done_valid high (or at a timeout).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output int lat, output logic [15:0] s, output logic co);
    int g;
    A_in = a; B_in = b; Cin_in = c; start_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!start_ready && g < 50) begin @(negedge clk); g++; end
    if (!start_ready) chk("accept_timeout", 32'(start_ready), 32'd1);
    @(posedge clk);
    #1 start_valid = 1'b0; acc_cyc = cyc;
    A_in = 16'h5A5A; B_in = 16'hA5A5; Cin_in = ~c;   // must be ignored
    lat = 0;
    forever begin
      @(negedge clk);
      if (done_valid || lat >= 50) break;
      if (lat < N) begin seq_a[lat] = add_a; seq_cin[lat] = add_cin; end
      @(posedge clk);
      lat++;
    end
    if (!done_valid) chk("done_timeout", 32'(done_valid), 32'd1);
    s = Sum; co = Cout;
  endtask

  int          lat, hs;
  logic [15:0] s;
  logic        co;
  bit          stop;

  initial begin
    rst = 1'b1; start_valid = 1'b0; A_in = '0; B_in = '0; Cin_in = 1'b0; done_ready = 1'b1;
    sv2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; dr2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_Sum", 32'(Sum), 32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 0x1234 + 0x1111
    start_op(16'h1234, 16'h1111, 1'b0, lat, s, co);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_Sum", 32'(s), 32'h2345);
    chk("t1_Cout", 32'(co), 32'd0);
    chk("t1_add_a_seq", 32'({seq_a[0], seq_a[1], seq_a[2], seq_a[3]}), 32'h4321);
    @(posedge clk); #1;

    // 0xFFFF + 0 + 1: carry ripples through every nibble
    start_op(16'hFFFF, 16'h0000, 1'b1, lat, s, co);
    chk("t2_cin_seq", 32'({seq_cin[0], seq_cin[1], seq_cin[2], seq_cin[3]}), 32'hF);
    chk("t2_Sum", 32'(s), 32'h0000);
    chk("t2_Cout", 32'(co), 32'd1);
    @(posedge clk); #1;

    // Result held while the consumer stalls
    done_ready = 1'b0;
    start_op(16'h9999, 16'h8888, 1'b0, lat, s, co);
    chk("t3_Sum", 32'(s), 32'h2221);
    chk("t3_Cout", 32'(co), 32'd1);
    A_in = 16'h1111; B_in = 16'h2222; start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("t3_hold_dv", 32'(done_valid), 32'd1);
      chk("t3_hold_Sum", 32'(Sum), 32'h2221);
      chk("t3_hold_Cout", 32'(Cout), 32'd1);
      chk("t3_hold_sr", 32'(start_ready), 32'd0);
    end
    @(posedge clk); #1 start_valid = 1'b0; done_ready = 1'b1;
    @(negedge clk);
    chk("t3_dv_before_hs", 32'(done_valid), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("t3_sr_after_hs", 32'(start_ready), 32'd1);
    chk("t3_dv_after_hs", 32'(done_valid), 32'd0);
    chk("t3_Sum_idle", 32'(Sum), 32'h2221);
    @(posedge clk); #1;

    // Reset in the second RUN cycle
    A_in = 16'hABCD; B_in = 16'h1234; Cin_in = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1 start_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t4_sr_in_rst", 32'(start_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_Sum", 32'(Sum), 32'd0);
    chk("t4_Cout", 32'(Cout), 32'd0);
    chk("t4_dv", 32'(done_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_sr", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_op(16'hABCD, 16'h1234, 1'b1, lat, s, co);
    chk("t4_fresh_Sum", 32'(s), 32'hBE02);
    chk("t4_fresh_Cout", 32'(co), 32'd0);
    @(posedge clk); #1;

    // Back-to-back
    start_op(16'h8000, 16'h8000, 1'b0, lat, s, co);
    chk("t5a_Sum", 32'(s), 32'h0000);
    chk("t5a_Cout", 32'(co), 32'd1);
    @(posedge clk); #1 hs = cyc;
    start_op(16'hABCD, 16'h1234, 1'b1, lat, s, co);
    chk("t5_accept_gap", 32'(acc_cyc - hs), 32'd1);
    chk("t5b_Sum", 32'(s), 32'hBE02);
    chk("t5b_Cout", 32'(co), 32'd0);
    @(posedge clk); #1;

    // 2-nibble sweep; stops at the first wrong result
    stop = 1'b0;
    for (int a = 0; a < 256 && !stop; a += 3) begin
      for (int b = 0; b < 256 && !stop; b += 15) begin
        for (int c = 0; c < 2 && !stop; c++) begin
          int g;
          logic [8:0] exp9;
          a2 = 8'(a); b2 = 8'(b); c2 = 1'(c); sv2 = 1'b1;
          g = 0;
          @(negedge clk);
          while (!sr2 && g < 20) begin @(negedge clk); g++; end
          if (!sr2) begin chk("n2_accept_timeout", 32'(sr2), 32'd1); stop = 1'b1; end
          else begin
            @(posedge clk); #1 sv2 = 1'b0;
            g = 0;
            @(negedge clk);
            while (!dv2 && g < 20) begin @(negedge clk); g++; end
            exp9 = 9'(a) + 9'(b) + 9'(c);
            if (!dv2) begin chk("n2_done_timeout", 32'(dv2), 32'd1); stop = 1'b1; end
            else begin
              n_checks++;
              if ({co2, s2} !== exp9) begin
                n_err++;
                $display("FAIL n2_sum a=%0h b=%0h c=%0d: got %0h expected %0h",
                         a, b, c, {co2, s2}, exp9);
                stop = 1'b1;
              end
            end
            @(posedge clk); #1;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
